// File: rtl/spi_master_rx_if.sv
// spi_master_rx_if: groups the SPI pins, the start/status strobes and the
// received-byte ready/valid stream of spi_master_rx.
// The master modport is the controller's view; the slave modport is the
// camera/consumer side.
interface spi_master_rx_if;
    logic       start;
    logic       miso;
    logic       sck;
    logic       cs_n;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       frame_end;

    modport master (
        input  start,
        input  miso,
        input  byte_ready,
        output sck,
        output cs_n,
        output byte_data,
        output byte_valid,
        output busy,
        output done,
        output frame_end
    );

    modport slave (
        output start,
        output miso,
        output byte_ready,
        input  sck,
        input  cs_n,
        input  byte_data,
        input  byte_valid,
        input  busy,
        input  done,
        input  frame_end
    );
endinterface

// File: rtl/spi_master_rx.sv
// spi_master_rx: SPI master that reads BURST_LEN bytes (MSB first) from a
// slave and presents them through a one-byte holding register with a
// valid/ready handshake. When the holding register is still full at byte
// completion, sck parks low until the consumer drains it.
// Optional feature, macro SPI_RX_MARKER_EN: a received 8'hFF byte pulses
// frame_end and ends the burst early.
module spi_master_rx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned BURST_LEN = 150,
    parameter int unsigned CS_SETUP  = 4
) (
    input logic             sys_clk,
    input logic             sys_rst,
    spi_master_rx_if.master bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StStall, StHold} state_e;

    localparam logic [7:0]  DivLast  = 8'(CLK_DIV - 1);
    localparam logic [3:0]  CsLast   = 4'(CS_SETUP - 1);
    localparam logic [11:0] ByteLast = 12'(BURST_LEN - 1);
    localparam logic [11:0] ByteLen  = 12'(BURST_LEN);

    state_e      state_q;
    logic [7:0]  div_cnt_q;
    logic [3:0]  cs_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [11:0] byte_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_data_q;
    logic        byte_valid_q;
    logic        sck_q;
    logic        cs_n_q;
    logic        busy_q;
    logic        done_q;
    logic        frame_end_q;

    logic [7:0]  sample_byte;
    logic        drain;
    logic        marker_new;
    logic        marker_held;

    // Byte as it stands once the current miso bit is shifted in.
    assign sample_byte = {shift_q[6:0], bus.miso};
    assign drain       = byte_valid_q & bus.byte_ready;

`ifdef SPI_RX_MARKER_EN
    assign marker_new  = (sample_byte == 8'hFF);
    assign marker_held = (shift_q == 8'hFF);
`else
    assign marker_new  = 1'b0;
    assign marker_held = 1'b0;
`endif

    // Burst sequencer: chip select, sck generation, sampling and holding register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            cs_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            sck_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frame_end_q <= 1'b0;
            // A load later in this block overrides the clear (load + drain same cycle).
            if (drain) begin
                byte_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    // done_q high means the previous burst ends this cycle: ignore start.
                    if (bus.start && !done_q) begin
                        state_q    <= StSetup;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_cnt_q   <= '0;
                        div_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end

                StSetup: begin
                    if (cs_cnt_q == CsLast) begin
                        state_q   <= StShift;
                        sck_q     <= 1'b1;
                        div_cnt_q <= '0;
                    end else begin
                        cs_cnt_q <= cs_cnt_q + 4'd1;
                    end
                end

                StShift: begin
                    if (div_cnt_q != DivLast) begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end else begin
                        div_cnt_q <= '0;
                        sck_q     <= ~sck_q;
                        // Falling edge: the slave's bit has been stable since the rise.
                        if (sck_q) begin
                            shift_q   <= sample_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_cnt_q <= byte_cnt_q + 12'd1;
                                if (byte_valid_q && !bus.byte_ready) begin
                                    // Completed byte waits in shift_q until drain.
                                    state_q <= StStall;
                                end else begin
                                    byte_data_q  <= sample_byte;
                                    byte_valid_q <= 1'b1;
                                    frame_end_q  <= marker_new;
                                    if ((byte_cnt_q == ByteLast) || marker_new) begin
                                        state_q  <= StHold;
                                        cs_cnt_q <= '0;
                                    end
                                end
                            end
                        end
                    end
                end

                StStall: begin
                    if (drain) begin
                        byte_data_q  <= shift_q;
                        byte_valid_q <= 1'b1;
                        frame_end_q  <= marker_held;
                        div_cnt_q    <= '0;
                        // byte_cnt_q already counts the parked byte.
                        if ((byte_cnt_q == ByteLen) || marker_held) begin
                            state_q  <= StHold;
                            cs_cnt_q <= '0;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end

                StHold: begin
                    if (cs_cnt_q == CsLast) begin
                        state_q <= StIdle;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cs_cnt_q <= cs_cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.sck        = sck_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.frame_end  = frame_end_q;

endmodule
